// File: rtl/chan_mux_if.sv
// Channel mux bus: N producer channels in, one consumer stream out, plus mode/select control.
// With CHAN_MUX_PKT_LOCK_EN defined the bus also carries in_last/out_last packet markers.
interface chan_mux_if #(
  parameter int WIDTH  = 4,
  parameter int NUM_CH = 6,
  parameter int SEL_W  = 3
) ();
  logic                    mode;
  logic [SEL_W-1:0]        sel;
  logic [NUM_CH*WIDTH-1:0] in_data;
  logic [NUM_CH-1:0]       in_valid;
  logic [NUM_CH-1:0]       in_ready;
  logic [WIDTH-1:0]        out_data;
  logic                    out_valid;
  logic                    out_ready;
  logic [SEL_W-1:0]        out_ch;
  logic                    sel_err;
`ifdef CHAN_MUX_PKT_LOCK_EN
  logic [NUM_CH-1:0]       in_last;
  logic                    out_last;

  modport master (
    output mode, sel, in_data, in_valid, in_last, out_ready,
    input  in_ready, out_data, out_valid, out_ch, sel_err, out_last
  );
  modport slave (
    input  mode, sel, in_data, in_valid, in_last, out_ready,
    output in_ready, out_data, out_valid, out_ch, sel_err, out_last
  );
`else
  modport master (
    output mode, sel, in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_ch, sel_err
  );
  modport slave (
    input  mode, sel, in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_ch, sel_err
  );
`endif
endinterface

// File: rtl/chan_mux_pipe.sv
// Registered N-to-1 channel mux with direct-select or round-robin grant and valid/ready handshakes.
// Optional packet lock (grant held until in_last) is enabled by defining CHAN_MUX_PKT_LOCK_EN.
module chan_mux_pipe #(
  parameter int               WIDTH       = 4,
  parameter int               NUM_CH      = 6,
  parameter int               SEL_W       = 3,
  parameter logic [WIDTH-1:0] DEFAULT_VAL = '0
) (
  input  logic      clk,
  input  logic      resetn,
  chan_mux_if.slave bus
);
  localparam int               DEPTH   = 2 ** SEL_W;
  localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(NUM_CH - 1);

  // Channel views padded to the full select range so any grant index is legal.
  logic [WIDTH-1:0] chan_data [DEPTH];
  logic [DEPTH-1:0] valid_pad;
  logic [DEPTH-1:0] last_pad;

  logic [WIDTH-1:0] out_data_reg;
  logic             out_valid_reg;
  logic [SEL_W-1:0] out_ch_reg;
  logic             sel_err_reg;
  logic [SEL_W-1:0] rr_ptr_reg;
  logic             lock_reg;
  logic [SEL_W-1:0] lock_ch_reg;

  logic             can_load;
  logic [SEL_W-1:0] grant;
  logic             grant_ok;
  logic             xfer;
  logic             beat_last;
  logic             sel_in_range;
  logic [SEL_W-1:0] hi_g, lo_g;
  logic             hi_found, lo_found;
  logic [SEL_W-1:0] rr_ptr_next;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_pad
      if (gi < NUM_CH) begin : g_ch
        assign chan_data[gi] = bus.in_data[gi*WIDTH +: WIDTH];
        assign valid_pad[gi] = bus.in_valid[gi];
`ifdef CHAN_MUX_PKT_LOCK_EN
        assign last_pad[gi]  = bus.in_last[gi];
`else
        assign last_pad[gi]  = 1'b1;
`endif
      end else begin : g_nc
        assign chan_data[gi] = '0;
        assign valid_pad[gi] = 1'b0;
        assign last_pad[gi]  = 1'b1;
      end
    end
  endgenerate

  // Round-robin search: lowest valid index at/above rr_ptr, else lowest below it (wrap).
  always_comb begin
    hi_g     = '0;
    hi_found = 1'b0;
    lo_g     = '0;
    lo_found = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (valid_pad[i] && (SEL_W'(i) >= rr_ptr_reg)) begin
        hi_g     = SEL_W'(i);
        hi_found = 1'b1;
      end
      if (valid_pad[i] && (SEL_W'(i) < rr_ptr_reg)) begin
        lo_g     = SEL_W'(i);
        lo_found = 1'b1;
      end
    end
  end

  assign sel_in_range = int'(bus.sel) < NUM_CH;
  assign can_load     = !out_valid_reg || bus.out_ready;

  always_comb begin
    grant    = bus.sel;
    grant_ok = sel_in_range;
    if (lock_reg) begin
      grant    = lock_ch_reg;
      grant_ok = 1'b1;
    end else if (bus.mode) begin
      grant    = hi_found ? hi_g : lo_g;
      grant_ok = hi_found || lo_found;
    end
  end

  assign xfer        = resetn && can_load && grant_ok && valid_pad[grant];
  assign beat_last   = last_pad[grant];
  assign rr_ptr_next = (grant == LAST_CH) ? '0 : grant + 1'b1;

  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_rdy
      assign bus.in_ready[gi] = resetn && can_load && grant_ok && (grant == SEL_W'(gi));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!resetn) begin
      out_data_reg  <= DEFAULT_VAL;
      out_valid_reg <= 1'b0;
      out_ch_reg    <= '0;
      sel_err_reg   <= 1'b0;
      rr_ptr_reg    <= '0;
    end else begin
      sel_err_reg <= !bus.mode && !sel_in_range;
      if (xfer) begin
        out_data_reg  <= chan_data[grant];
        out_ch_reg    <= grant;
        out_valid_reg <= 1'b1;
        if (bus.mode && beat_last) begin
          rr_ptr_reg <= rr_ptr_next;
        end
      end else if (bus.out_ready) begin
        out_valid_reg <= 1'b0;
      end
    end
  end

`ifdef CHAN_MUX_PKT_LOCK_EN
  logic out_last_reg;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      lock_reg     <= 1'b0;
      lock_ch_reg  <= '0;
      out_last_reg <= 1'b0;
    end else if (xfer) begin
      lock_reg     <= !beat_last;
      lock_ch_reg  <= grant;
      out_last_reg <= beat_last;
    end
  end

  assign bus.out_last = out_last_reg;
`else
  assign lock_reg    = 1'b0;
  assign lock_ch_reg = '0;
`endif

  assign bus.out_data  = out_data_reg;
  assign bus.out_valid = out_valid_reg;
  assign bus.out_ch    = out_ch_reg;
  assign bus.sel_err   = sel_err_reg;
endmodule

// File: tb/tb_chan_mux_pipe.sv
// Bench for chan_mux_pipe: directed steps then randomized traffic checked against a behavioural model.
// Packet-lock steps run only when CHAN_MUX_PKT_LOCK_EN is defined.
module tb_chan_mux_pipe;
  localparam int WIDTH  = 4;
  localparam int NUM_CH = 6;
  localparam int SEL_W  = 3;

  logic clk;
  logic resetn;
  int   tests = 0;
  int   fails = 0;

  chan_mux_if #(.WIDTH(WIDTH), .NUM_CH(NUM_CH), .SEL_W(SEL_W)) bus ();

  chan_mux_pipe #(.WIDTH(WIDTH), .NUM_CH(NUM_CH), .SEL_W(SEL_W), .DEFAULT_VAL('0)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model state.
  bit         m_ov, m_serr, m_lock, m_olast;
  int         m_od, m_och, m_rr, m_lch;
  // Observations from the most recent tick.
  logic [NUM_CH-1:0] obs_rdy;
  bit                last_xfer;
  int                last_g;

  function automatic void chk(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endfunction

  function automatic bit in_last_of(int c);
`ifdef CHAN_MUX_PKT_LOCK_EN
    return bus.in_last[c];
`else
    return 1'b1;
`endif
  endfunction

  // Grant from the rules: lock wins, else sel, else first valid channel rotating from rr.
  function automatic int model_grant();
    int c;
    if (m_lock) return m_lch;
    if (!bus.mode) return (int'(bus.sel) < NUM_CH) ? int'(bus.sel) : -1;
    for (int k = 0; k < NUM_CH; k++) begin
      c = (m_rr + k) % NUM_CH;
      if (bus.in_valid[c]) return c;
    end
    return -1;
  endfunction

  task automatic tick(string tag);
    int                g;
    bit                xfer;
    logic [NUM_CH-1:0] exp_rdy;
    #1;
    g       = model_grant();
    exp_rdy = '0;
    xfer    = 1'b0;
    if (resetn && (!m_ov || bus.out_ready) && g >= 0) begin
      exp_rdy[g] = 1'b1;
      xfer       = bus.in_valid[g];
    end
    obs_rdy = bus.in_ready;
    chk({tag, ".in_ready"}, 32'(bus.in_ready), 32'(exp_rdy));
    last_xfer = xfer;
    last_g    = g;
    @(posedge clk);
    #1;
    if (!resetn) begin
      m_ov = 0; m_od = 0; m_och = 0; m_rr = 0; m_serr = 0; m_lock = 0; m_lch = 0; m_olast = 0;
    end else begin
      m_serr = !bus.mode && (int'(bus.sel) >= NUM_CH);
      if (xfer) begin
        m_od    = int'(bus.in_data[g*WIDTH +: WIDTH]);
        m_och   = g;
        m_ov    = 1;
        m_olast = in_last_of(g);
        if (bus.mode && in_last_of(g)) m_rr = (g + 1) % NUM_CH;
        m_lock  = !in_last_of(g);
        m_lch   = g;
      end else if (bus.out_ready) begin
        m_ov = 0;
      end
    end
    if (xfer) $display("[TB] %s: accepted ch=%0d data=%0h", tag, g, m_od);
    chk({tag, ".out_valid"}, 32'(bus.out_valid), 32'(m_ov));
    chk({tag, ".out_data"},  32'(bus.out_data),  32'(m_od));
    chk({tag, ".out_ch"},    32'(bus.out_ch),    32'(m_och));
    chk({tag, ".sel_err"},   32'(bus.sel_err),   32'(m_serr));
`ifdef CHAN_MUX_PKT_LOCK_EN
    chk({tag, ".out_last"},  32'(bus.out_last),  32'(m_olast));
`endif
  endtask

  initial begin
    int order [5];
    logic [WIDTH-1:0] held_d;
    logic [SEL_W-1:0] held_c;
    order = '{0, 2, 5, 0, 2};

    resetn        = 1'b0;
    bus.mode      = 1'b0;
    bus.sel       = '0;
    bus.in_data   = 24'h123456;
    bus.in_valid  = 6'h3F;
    bus.out_ready = 1'b1;
`ifdef CHAN_MUX_PKT_LOCK_EN
    bus.in_last   = 6'h3F;
`endif

    // Reset with every channel valid.
    tick("reset0");
    chk("reset0.rdy_zero", 32'(obs_rdy), 32'h0);
    tick("reset1");
    chk("reset1.out_data", 32'(bus.out_data), 32'h0);

    // Direct select of channel 3.
    resetn = 1'b1; bus.sel = 3'd3; bus.in_valid = 6'b001000; bus.in_data = 24'h00A000;
    tick("direct");
    chk("direct.rdy", 32'(obs_rdy), 32'b001000);
    chk("direct.data", 32'(bus.out_data), 32'hA);
    chk("direct.ch", 32'(bus.out_ch), 32'd3);

    // Out-of-range select, then recovery on sel=0.
    bus.sel = 3'd7; bus.in_valid = 6'h3F; bus.in_data = 24'h654321;
    tick("oor");
    chk("oor.rdy", 32'(obs_rdy), 32'h0);
    chk("oor.sel_err", 32'(bus.sel_err), 32'h1);
    bus.sel = 3'd0;
    tick("oor_clr");
    chk("oor_clr.sel_err", 32'(bus.sel_err), 32'h0);
    chk("oor_clr.xfer", 32'(last_xfer), 32'h1);
    chk("oor_clr.ch", 32'(bus.out_ch), 32'h0);

    // Round-robin over channels 0, 2, 5.
    bus.mode = 1'b1; bus.in_valid = 6'b100101;
    for (int k = 0; k < 5; k++) begin
      bus.in_data = 24'($urandom);
      tick("rr");
      chk("rr.xfer", 32'(last_xfer), 32'h1);
      chk("rr.order", 32'(bus.out_ch), 32'(order[k]));
    end

    // Backpressure: held beat stays stable, then drains and reloads in one cycle.
    held_d = bus.out_data; held_c = bus.out_ch;
    bus.out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      bus.in_data = 24'($urandom);
      tick("bp");
      chk("bp.rdy", 32'(obs_rdy), 32'h0);
      chk("bp.data_stable", 32'(bus.out_data), 32'(held_d));
      chk("bp.ch_stable", 32'(bus.out_ch), 32'(held_c));
    end
    bus.out_ready = 1'b1;
    tick("bp_drain");
    chk("bp_drain.xfer", 32'(last_xfer), 32'h1);

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      resetn        = ($urandom_range(0, 40) != 0);
      bus.mode      = ($urandom_range(0, 1) == 1);
      bus.sel       = SEL_W'($urandom_range(0, 7));
      bus.in_valid  = NUM_CH'($urandom);
      bus.in_data   = 24'($urandom);
      bus.out_ready = ($urandom_range(0, 3) != 0);
`ifdef CHAN_MUX_PKT_LOCK_EN
      bus.in_last   = NUM_CH'($urandom);
`endif
      tick("rand");
    end

`ifdef CHAN_MUX_PKT_LOCK_EN
    // Three-beat packet on ch1 holds the grant while ch2 waits.
    resetn = 1'b0; bus.out_ready = 1'b1;
    tick("pkt_rst");
    resetn = 1'b1; bus.mode = 1'b1; bus.in_valid = 6'b000110;
    for (int k = 0; k < 4; k++) begin
      bus.in_last = (k == 2) ? 6'b000110 : 6'b000100;
      bus.in_data = 24'($urandom);
      tick("pkt");
      chk("pkt.ch", 32'(bus.out_ch), (k < 3) ? 32'd1 : 32'd2);
      chk("pkt.last", 32'(bus.out_last), (k >= 2) ? 32'h1 : 32'h0);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
